// File: rtl/qbc_pkg.sv
// Shared types, constants and phase helper for the quadrature BCD rotation counter.
package qbc_pkg;

    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH01 = 2'b01,
        PH11 = 2'b11,
        PH10 = 2'b10
    } phase_t;

    typedef enum logic {
        UNPRIMED = 1'b0,
        TRACK    = 1'b1
    } fsm_t;

    typedef enum logic {
        STEP_X1 = 1'b0,
        STEP_X4 = 1'b1
    } step_mode_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] DIGIT_MIN = 4'd0;

    // Position in the up sequence 00->01->11->10; a difference of +1/-1 (mod 4)
    // is a legal step, +2 means a phase was skipped.
    function automatic logic [1:0] phase_pos(phase_t ph);
        case (ph)
            PH00:    phase_pos = 2'd0;
            PH01:    phase_pos = 2'd1;
            PH11:    phase_pos = 2'd2;
            PH10:    phase_pos = 2'd3;
            default: phase_pos = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-flop synchroniser followed by a debouncer that accepts a
// new level only after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module quad_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic [7:0] diff_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others; blocking here would collapse the synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            diff_cnt <= '0;
            dout     <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 != dout) begin
                if (diff_cnt == LAST_COUNT) begin
                    dout     <= sync_2;
                    diff_cnt <= '0;
                end else begin
                    diff_cnt <= diff_cnt + 8'd1;
                end
            end else begin
                diff_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_bcd_counter.sv
// Quadrature rotation counter with NUM_DIGITS-digit BCD position, x1/x4 modes and
// sticky illegal-transition flag. Define QBC_SATURATE_EN to hold at all-9s/all-0s.
module quad_bcd_counter
    import qbc_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    q_a,
    input  logic                    q_b,
    input  logic                    step_mode,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    count_evt,
    output logic                    dir,
    output logic                    error
);

    // The FSM stays unprimed until a level held through reset release has had
    // time to cross the synchroniser and debouncer.
    localparam logic [8:0] PRIME_CYCLES = 9'(DEBOUNCE_CYCLES + 2);

    logic       a_f;
    logic       b_f;
    phase_t     p;
    phase_t     prev;
    fsm_t       state;
    fsm_t       state_nx;
    step_mode_t mode;
    logic [8:0] prime_cnt;
    logic       primed;
    logic [1:0] delta;
    logic       step_up;
    logic       step_dn;
    logic       illegal;
    logic       count_en;
    logic       overflow;
    logic       hold;
    logic       do_count;

    logic [4*NUM_DIGITS-1:0] digits_inc;
    logic [4*NUM_DIGITS-1:0] digits_dec;
    logic [NUM_DIGITS:0]     carry;
    logic [NUM_DIGITS:0]     borrow;

    quad_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_a (
        .clk  (clk),
        .rst  (rst),
        .din  (q_a),
        .dout (a_f)
    );

    quad_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_b (
        .clk  (clk),
        .rst  (rst),
        .din  (q_b),
        .dout (b_f)
    );

    assign p      = phase_t'({a_f, b_f});
    assign mode   = step_mode_t'(step_mode);
    assign primed = (prime_cnt == PRIME_CYCLES);
    assign delta  = phase_pos(p) - phase_pos(prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= UNPRIMED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == UNPRIMED && primed) begin
            state_nx = TRACK;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        if (state == TRACK) begin
            case (delta)
                2'd1:    step_up = 1'b1;
                2'd3:    step_dn = 1'b1;
                2'd2:    illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // Ripple BCD increment and decrement chains; the final carry/borrow flags
    // the all-9s / all-0s boundary.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_bcd
        logic [3:0] d;
        assign d = digits[4*i +: 4];

        assign carry[i+1]       = carry[i] && (d == DIGIT_MAX);
        assign borrow[i+1]      = borrow[i] && (d == DIGIT_MIN);
        assign digits_inc[4*i +: 4] = !carry[i]  ? d :
                                      (d == DIGIT_MAX) ? DIGIT_MIN : d + 4'd1;
        assign digits_dec[4*i +: 4] = !borrow[i] ? d :
                                      (d == DIGIT_MIN) ? DIGIT_MAX : d - 4'd1;
    end

    assign count_en = (step_up || step_dn) && (mode == STEP_X4 || p == PH00);
    assign overflow = step_up ? carry[NUM_DIGITS] : borrow[NUM_DIGITS];

`ifdef QBC_SATURATE_EN
    assign hold = overflow;
`else
    assign hold = 1'b0;
`endif

    assign do_count = count_en && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_cnt <= '0;
            prev      <= PH00;
            digits    <= '0;
            count_evt <= 1'b0;
            dir       <= 1'b1;
            error     <= 1'b0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + 9'd1;
            end
            prev      <= p;
            count_evt <= 1'b0;
            if (clear) begin
                digits <= '0;
                error  <= 1'b0;
            end else begin
                if (illegal) begin
                    error <= 1'b1;
                end
                if (do_count) begin
                    digits    <= step_up ? digits_inc : digits_dec;
                    dir       <= step_up;
                    count_evt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_bcd_counter.sv
// Self-checking bench for quad_bcd_counter: vector table, corner sequences and a
// randomized walk against an arithmetic position model.
module tb_quad_bcd_counter;

    localparam int NUM_DIGITS      = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LATENCY         = DEBOUNCE_CYCLES + 3;
    localparam int COUNT_MAX       = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_a;
    logic        q_b;
    logic        step_mode;
    logic        clear;
    logic [15:0] digits;
    logic        count_evt;
    logic        dir;
    logic        error;

    quad_bcd_counter #(
        .NUM_DIGITS      (NUM_DIGITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_a       (q_a),
        .q_b       (q_b),
        .step_mode (step_mode),
        .clear     (clear),
        .digits    (digits),
        .count_evt (count_evt),
        .dir       (dir),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int evt_total = 0;

    always @(negedge clk) if (rst === 1'b1 && count_evt === 1'b1) evt_total++;

    // Reference model: position as an integer, phase as its place in the up cycle.
    int m_count;
    int m_prev;
    bit m_err;
    bit m_dir;

    typedef struct {
        int          pos;
        bit          mode;
        logic [15:0] exp_digits;
        bit          exp_evt;
        bit          exp_dir;
    } vec_t;

    vec_t tbl[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic bit pos_a(input int pos);
        return pos >= 2;
    endfunction

    function automatic bit pos_b(input int pos);
        return pos == 1 || pos == 2;
    endfunction

    task automatic model_reset(input int pos);
        m_count = 0;
        m_prev  = pos;
        m_err   = 1'b0;
        m_dir   = 1'b1;
    endtask

    function automatic bit model_step(input int n, input bit x4, input bit clr);
        int  d;
        bit  evt;
        bit  up;
        d      = (n - m_prev + 4) % 4;
        m_prev = n;
        evt    = 1'b0;
        if (clr) begin
            m_count = 0;
            m_err   = 1'b0;
            return 1'b0;
        end
        if (d == 2) m_err = 1'b1;
        if ((d == 1 || d == 3) && (x4 || n == 0)) begin
            up = (d == 1);
`ifdef QBC_SATURATE_EN
            if (!(up && m_count == COUNT_MAX) && !(!up && m_count == 0)) begin
                m_count = up ? m_count + 1 : m_count - 1;
                m_dir   = up;
                evt     = 1'b1;
            end
`else
            m_count = up ? (m_count + 1) % (COUNT_MAX + 1) : (m_count + COUNT_MAX) % (COUNT_MAX + 1);
            m_dir   = up;
            evt     = 1'b1;
`endif
        end
        return evt;
    endfunction

    // Entered and left #1 after a rising edge. Drives phase position n, checks the
    // pulse lands exactly LATENCY edges later and lasts one cycle.
    task automatic run_step(input int n, input bit clr, output bit got_evt);
        bit exp_evt;
        exp_evt = model_step(n, step_mode, clr);
        q_a = pos_a(n);
        q_b = pos_b(n);
        for (int k = 1; k <= LATENCY; k++) begin
            @(posedge clk);
            #1;
            if (k < LATENCY) check("evt_early", count_evt, 0);
            else             check("evt_on_time", count_evt, exp_evt);
            if (clr && k == LATENCY - 1) clear = 1'b1;
        end
        got_evt = count_evt;
        clear   = 1'b0;
        check("step_digits", digits, to_bcd(m_count));
        check("step_dir", dir, m_dir);
        check("step_error", error, m_err);
        @(posedge clk);
        #1;
        check("evt_width", count_evt, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
        check("clear_digits", digits, 16'h0000);
        check("clear_error", error, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int e0;
        int c;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{pos: (i + 1) % 4, mode: 1'b1, exp_digits: to_bcd(i + 1),
                       exp_evt: 1'b1, exp_dir: 1'b1};
        end
        for (int j = 0; j < 16; j++) begin
            c = (j + 1) / 4;
            tbl[16+j].pos  = (4 - (j + 1) % 4) % 4;
            tbl[16+j].mode = 1'b0;
`ifdef QBC_SATURATE_EN
            tbl[16+j].exp_digits = 16'h0000;
            tbl[16+j].exp_evt    = 1'b0;
            tbl[16+j].exp_dir    = 1'b1;
`else
            tbl[16+j].exp_digits = to_bcd(c == 0 ? 0 : 10000 - c);
            tbl[16+j].exp_evt    = (tbl[16+j].pos == 0);
            tbl[16+j].exp_dir    = (c == 0);
`endif
        end

        rst = 1'b0; q_a = 1'b0; q_b = 1'b0; step_mode = 1'b1; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", digits, 16'h0000);
        check("rst_evt", count_evt, 0);
        check("rst_dir", dir, 1);
        check("rst_error", error, 0);
        rst = 1'b1;
        model_reset(0);
        repeat (12) @(posedge clk);
        #1;
        check("prime_digits", digits, 16'h0000);
        check("prime_error", error, 0);
        check("prime_pulses", evt_total, 0);

        e0 = evt_total;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                check("x4_up_pulses", evt_total - e0, 16);
                check("x4_up_final", digits, 16'h0016);
                do_clear();
                e0 = evt_total;
            end
            step_mode = tbl[i].mode;
            run_step(tbl[i].pos, 1'b0, got);
            check("tbl_digits", digits, tbl[i].exp_digits);
            check("tbl_evt", got, tbl[i].exp_evt);
            check("tbl_dir", dir, tbl[i].exp_dir);
        end
`ifdef QBC_SATURATE_EN
        check("x1_down_final", digits, 16'h0000);
        check("x1_down_pulses", evt_total - e0, 0);
`else
        check("x1_down_final", digits, 16'h9996);
        check("x1_down_pulses", evt_total - e0, 4);
`endif

        // Glitch of three synchronised samples on A must vanish.
        e0 = evt_total;
        q_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        q_a = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("glitch_evt", count_evt, 0);
        end
        check("glitch_digits", digits, to_bcd(m_count));
        check("glitch_error", error, 0);
        check("glitch_pulses", evt_total - e0, 0);

        // Two-bit jump: error, no count; later legal steps still count.
        c = m_count;
        step_mode = 1'b1;
        run_step((m_prev + 2) % 4, 1'b0, got);
        check("jump_error", error, 1);
        check("jump_digits", digits, to_bcd(c));
        check("jump_evt", got, 0);
        run_step((m_prev + 1) % 4, 1'b0, got);
        check("after_jump_evt", got, 1);
        check("after_jump_error", error, 1);
        do_clear();

        // Clear coinciding with an accepted up step.
        run_step((m_prev + 1) % 4, 1'b1, got);
        check("clr_step_digits", digits, 16'h0000);
        check("clr_step_evt", got, 0);

        for (int r = 0; r < 60; r++) begin
            int sel;
            sel = $urandom_range(0, 15);
            step_mode = ($urandom_range(0, 3) != 0);
            if (sel == 0)      do_clear();
            else if (sel == 1) run_step((m_prev + 2) % 4, 1'b0, got);
            else if (sel == 2) run_step((m_prev + 1) % 4, 1'b1, got);
            else if (sel < 11) run_step((m_prev + 1) % 4, 1'b0, got);
            else               run_step((m_prev + 3) % 4, 1'b0, got);
        end

        // Reset mid-rotation with 11 held through release.
        rst = 1'b0;
        q_a = 1'b1;
        q_b = 1'b1;
        #1;
        check("rst2_digits", digits, 16'h0000);
        check("rst2_evt", count_evt, 0);
        check("rst2_dir", dir, 1);
        check("rst2_error", error, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset(2);
        e0 = evt_total;
        repeat (15) @(posedge clk);
        #1;
        check("hold11_error", error, 0);
        check("hold11_digits", digits, 16'h0000);
        check("hold11_pulses", evt_total - e0, 0);
        step_mode = 1'b1;
        run_step(3, 1'b0, got);
        check("hold11_step_digits", digits, 16'h0001);
        check("hold11_step_evt", got, 1);
        check("hold11_step_pulses", evt_total - e0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
